btb_ctrl: RTL and testbench

BTB_CTRL -- requirements
Module: btb_ctrl

---
 rtl/btb_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_btb_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// BTB maintenance controller: power-up/flush invalidation sweep, a 2-entry
// update queue from WB, and starvation-bounded arbitration against fetch.
module btb_ctrl #(
  parameter int SET_BITS   = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wb_valid,
  input  logic [15:0]         wb_pc,
  input  logic [15:0]         wb_target,
  input  logic                wb_taken,
  output logic                wb_ready,
  input  logic                fetch_req,
  output logic                fetch_grant,
  input  logic                flush_req,
  output logic                upd_valid,
  output logic [15:0]         upd_pc,
  output logic [15:0]         upd_target,
  output logic                upd_taken,
  output logic                inv_valid,
  output logic [SET_BITS-1:0] inv_index,
  output logic                busy
);

  localparam int SETS = 1 << SET_BITS;
  localparam int SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SET_BITS-1:0] CNT_LAST   = SET_BITS'(SETS - 1);
  localparam logic [SW-1:0]       STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          count_q, count_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [SW-1:0]       starve_q, starve_d;

  logic [15:0]         pc_q  [2];
  logic [15:0]         tgt_q [2];
  logic                tk_q  [2];

  logic                wb_ready_s;
  logic                fetch_grant_s;
  logic                upd_valid_s;
  logic                inv_valid_s;
  logic [SET_BITS-1:0] inv_index_s;
  logic                push_s;
  logic                pop_s;

  // Port ownership and handshake outputs; everything is forced low in reset.
  always_comb begin
    wb_ready_s    = 1'b0;
    fetch_grant_s = 1'b0;
    upd_valid_s   = 1'b0;
    inv_valid_s   = 1'b0;
    inv_index_s   = {SET_BITS{1'b0}};
    if (reset_n) begin
      case (state_q)
        ST_SWEEP: begin
          inv_valid_s = 1'b1;
          inv_index_s = cnt_q;
        end
        ST_RUN: begin
          wb_ready_s = (count_q != 2'd2);
          if (count_q == 2'd0) begin
            fetch_grant_s = fetch_req;
          end else if (!fetch_req || (starve_q == STARVE_LIM)) begin
            upd_valid_s = 1'b1;
          end else begin
            fetch_grant_s = 1'b1;
          end
        end
        default: begin
          inv_valid_s = 1'b0;
        end
      endcase
    end else begin
      inv_valid_s = 1'b0;
    end
  end

  // A flush cancels whatever transfer the handshakes would otherwise commit.
  assign push_s = wb_valid && wb_ready_s && !flush_req;
  assign pop_s  = upd_valid_s && !flush_req;

  // Next-state: sweep sequencing, queue pointers and the starvation count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    starve_d = starve_q;
    if (flush_req) begin
      state_d  = ST_SWEEP;
      cnt_d    = {SET_BITS{1'b0}};
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      starve_d = {SW{1'b0}};
    end else begin
      case (state_q)
        ST_SWEEP: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            cnt_d   = {SET_BITS{1'b0}};
          end else begin
            cnt_d   = cnt_q + SET_BITS'(1);
          end
        end
        ST_RUN: begin
          if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
          if (push_s) begin
            wr_ptr_d = ~wr_ptr_q;
          end else begin
            wr_ptr_d = wr_ptr_q;
          end
          count_d = count_q + 2'(push_s) - 2'(pop_s);
          if ((count_q == 2'd0) || upd_valid_s) begin
            starve_d = {SW{1'b0}};
          end else if (fetch_grant_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
          end else begin
            starve_d = starve_q;
          end
        end
        default: begin
          state_d = ST_SWEEP;
          cnt_d   = {SET_BITS{1'b0}};
        end
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_SWEEP;
      cnt_q    <= {SET_BITS{1'b0}};
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      starve_q <= {SW{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      starve_q <= starve_d;
    end
  end

  // Queue storage; cleared in reset so no stale entry can ever leak out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]  <= 16'h0000;
        tgt_q[i] <= 16'h0000;
        tk_q[i]  <= 1'b0;
      end
    end else if (push_s) begin
      pc_q[wr_ptr_q]  <= wb_pc;
      tgt_q[wr_ptr_q] <= wb_target;
      tk_q[wr_ptr_q]  <= wb_taken;
    end else begin
      pc_q[wr_ptr_q]  <= pc_q[wr_ptr_q];
    end
  end

  assign wb_ready    = wb_ready_s;
  assign fetch_grant = fetch_grant_s;
  assign upd_valid   = upd_valid_s;
  assign upd_pc      = upd_valid_s ? pc_q[rd_ptr_q]  : 16'h0000;
  assign upd_target  = upd_valid_s ? tgt_q[rd_ptr_q] : 16'h0000;
  assign upd_taken   = upd_valid_s ? tk_q[rd_ptr_q]  : 1'b0;
  assign inv_valid   = inv_valid_s;
  assign inv_index   = inv_index_s;
  assign busy        = reset_n && ((state_q == ST_SWEEP) || (count_q != 2'd0));

endmodule

// Protocol invariants on the controller outputs.
module btb_ctrl_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic wb_ready_i,
  input logic fetch_grant_i,
  input logic upd_valid_i,
  input logic inv_valid_i
);

  a_port_excl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fetch_grant_i && upd_valid_i));

  a_sweep_quiet: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    inv_valid_i |-> !(fetch_grant_i || upd_valid_i || wb_ready_i));

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed + randomized bench for btb_ctrl, checked every cycle against a
// queue-based reference model of the sweep/queue/arbitration rules.
module tb_btb_ctrl;

  localparam int SB = 3;
  localparam int SM = 3;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          reset_n, wb_valid, wb_taken, fetch_req, flush_req;
  logic [15:0]   wb_pc, wb_target;
  logic          wb_ready, fetch_grant, upd_valid, upd_taken, inv_valid, busy;
  logic [15:0]   upd_pc, upd_target;
  logic [SB-1:0] inv_index;

  always #5 clk = ~clk;

  btb_ctrl #(.SET_BITS(SB), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_target(wb_target), .wb_taken(wb_taken), .wb_ready(wb_ready),
    .fetch_req(fetch_req), .fetch_grant(fetch_grant), .flush_req(flush_req),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .inv_valid(inv_valid), .inv_index(inv_index),
    .busy(busy)
  );

  btb_ctrl_chk chk_i (
    .clk_i(clk), .reset_n_i(reset_n), .wb_ready_i(wb_ready),
    .fetch_grant_i(fetch_grant), .upd_valid_i(upd_valid), .inv_valid_i(inv_valid)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        tk;
  } ent_t;

  ent_t mq[$];
  bit   m_sweep;
  int   m_idx;
  int   m_starve;
  int   tests;
  int   fails;

  logic          ob_ready, ob_fg, ob_uv, ob_inv, ob_busy;
  logic [SB-1:0] ob_idx;
  logic [15:0]   ob_pc;
  logic [4:0]    pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sweep  = 1'b1;
    m_idx    = 0;
    m_starve = 0;
  endtask

  // One clock: check outputs at negedge against the model, then advance it.
  task automatic cyc();
    bit   e_ready, e_fg, e_uv, e_inv, e_busy, was_empty;
    ent_t ne;
    @(negedge clk);
    ob_ready = wb_ready; ob_fg = fetch_grant; ob_uv = upd_valid;
    ob_inv = inv_valid; ob_busy = busy; ob_idx = inv_index; ob_pc = upd_pc;
    e_ready = 1'b0; e_fg = 1'b0; e_uv = 1'b0; e_inv = 1'b0; e_busy = 1'b0;
    if (reset_n) begin
      e_busy  = m_sweep || (mq.size() > 0);
      e_inv   = m_sweep;
      e_ready = !m_sweep && (mq.size() < 2);
      if (!m_sweep) begin
        if (mq.size() == 0) e_fg = fetch_req;
        else if (!fetch_req || m_starve == SM) e_uv = 1'b1;
        else e_fg = 1'b1;
      end
    end
    chk("wb_ready", 32'(wb_ready), 32'(e_ready));
    chk("fetch_grant", 32'(fetch_grant), 32'(e_fg));
    chk("upd_valid", 32'(upd_valid), 32'(e_uv));
    chk("inv_valid", 32'(inv_valid), 32'(e_inv));
    chk("busy", 32'(busy), 32'(e_busy));
    if (!reset_n) begin
      chk("rst_inv_index", 32'(inv_index), 32'd0);
      chk("rst_upd_fields", {15'd0, upd_pc, upd_taken}, 32'd0);
      chk("rst_upd_target", 32'(upd_target), 32'd0);
    end else if (e_inv) begin
      chk("inv_index", 32'(inv_index), 32'(m_idx));
    end else if (e_uv) begin
      chk("upd_pc", 32'(upd_pc), 32'(mq[0].pc));
      chk("upd_target", 32'(upd_target), 32'(mq[0].tgt));
      chk("upd_taken", 32'(upd_taken), 32'(mq[0].tk));
    end
    @(posedge clk);
    if (!reset_n || flush_req) begin
      model_reset();
    end else if (m_sweep) begin
      if (m_idx == NS - 1) begin
        m_sweep = 1'b0;
        m_idx   = 0;
      end else begin
        m_idx++;
      end
    end else begin
      was_empty = (mq.size() == 0);
      if (e_uv) void'(mq.pop_front());
      if (wb_valid && e_ready) begin
        ne.pc = wb_pc; ne.tgt = wb_target; ne.tk = wb_taken;
        mq.push_back(ne);
      end
      if (was_empty || e_uv) m_starve = 0;
      else if (e_fg && m_starve < SM) m_starve++;
    end
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; pat = 5'd0;
    reset_n = 1'b0; wb_valid = 1'b0; wb_pc = 16'h0000; wb_target = 16'h0000;
    wb_taken = 1'b0; fetch_req = 1'b0; flush_req = 1'b0;
    model_reset();
    repeat (3) cyc();

    // Reset release: full sweep then idle RUN
    reset_n = 1'b1;
    cyc();
    chk("first_idx", 32'(ob_idx), 32'd0);
    chk("first_busy", 32'(ob_busy), 32'd1);
    repeat (7) cyc();
    cyc();
    chk("run_ready", 32'(ob_ready), 32'd1);
    chk("run_idle", 32'(ob_busy), 32'd0);

    // Back-to-back pushes with fetch idle
    wb_valid = 1'b1; wb_pc = 16'h1000; wb_target = 16'h1100; wb_taken = 1'b1;
    cyc();
    chk("no_bypass", 32'(ob_uv), 32'd0);
    wb_pc = 16'h2000; wb_target = 16'h2200; wb_taken = 1'b0;
    cyc();
    chk("upd_first", 32'(ob_pc), 32'h1000);
    wb_valid = 1'b0;
    cyc();
    chk("upd_second", 32'(ob_pc), 32'h2000);
    cyc();

    // Starvation bound with fetch held
    wb_valid = 1'b1; wb_pc = 16'h3000; fetch_req = 1'b1;
    cyc();
    wb_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      pat[i] = ob_uv;
    end
    chk("starve_pattern", 32'(pat), 32'h8);

    // Flush while full, with a same-cycle push
    wb_valid = 1'b1; wb_pc = 16'h4000;
    cyc();
    wb_pc = 16'h5000;
    cyc();
    wb_pc = 16'h6000; flush_req = 1'b1;
    cyc();
    chk("full_not_ready", 32'(ob_ready), 32'd0);
    flush_req = 1'b0; wb_valid = 1'b0; fetch_req = 1'b0;
    cyc();
    chk("flush_idx0", 32'(ob_idx), 32'd0);
    repeat (7) cyc();
    cyc();
    chk("flush_q_empty", 32'(ob_busy), 32'd0);

    // Flush mid-sweep at index 5
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    repeat (5) cyc();
    flush_req = 1'b1;
    cyc();
    chk("sweep_at5", 32'(ob_idx), 32'd5);
    flush_req = 1'b0;
    cyc();
    chk("restart_idx0", 32'(ob_idx), 32'd0);
    repeat (7) cyc();
    cyc();
    chk("restart_run", 32'(ob_ready), 32'd1);

    // Reset with a queued entry, then reset mid-sweep at index 3
    fetch_req = 1'b1; wb_valid = 1'b1; wb_pc = 16'h7000;
    cyc();
    wb_valid = 1'b0; reset_n = 1'b0;
    cyc();
    chk("rst_grant", 32'(ob_fg), 32'd0);
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("pre_rst_idx", 32'(ob_idx), 32'd2);
    reset_n = 1'b0;
    cyc();
    chk("rst_inv", 32'(ob_inv), 32'd0);
    reset_n = 1'b1;
    cyc();
    chk("rst_restart_idx", 32'(ob_idx), 32'd0);
    repeat (7) cyc();
    cyc();
    chk("rst_q_empty", 32'(ob_busy), 32'(fetch_req && 1'b0));

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      flush_req = ($urandom_range(0, 29) == 0);
      wb_valid  = 1'($urandom);
      fetch_req = ($urandom_range(0, 9) < 6);
      wb_pc     = 16'($urandom);
      wb_target = 16'($urandom);
      wb_taken  = 1'($urandom);
      cyc();
    end
    reset_n = 1'b1; flush_req = 1'b0; wb_valid = 1'b0; fetch_req = 1'b0;
    repeat (12) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
